assoc_data_cache: RTL and testbench
===================================

Name: assoc_data_cache

Overview:
Parametrised N-way set-associative, write-through, no-write-allocate data cache for the RISC-V core's data memory path. Sits between the LSU (valid/ready request, response strobe) and data memory (valid/ready request, read-data strobe). Replaces the direct-mapped, single-word, fixed-latency cache with configurable ways, byte-enabled writes, an LRU victim policy, a miss/refill FSM and a flush.

Parameters:
ADDRESS_WIDTH, 17, byte address width
DATA_WIDTH, 32, word width; must be 32 (4 byte enables)
SET_ADDRESS_WIDTH, 3, log2(sets)
WAYS, 2, associativity; 1, 2, 4 or 8
TAG_WIDTH, ADDRESS_WIDTH-SET_ADDRESS_WIDTH-2, derived tag width

Ports:
CLK  in  1  clock
RST_N  in  1  async active-low reset
req_valid  in  1  LSU request present
req_ready  out  1  cache accepts a request this cycle
req_write  in  1  1=store, 0=load
A  in  ADDRESS_WIDTH  byte address
WD  in  32  store data
WE  in  4  store byte enables; WE[3] is WD[31:24]
flush  in  1  invalidate all lines
resp_valid  out  1  one-cycle completion strobe
RD  out  32  load data, valid with resp_valid
hit_o  out  1  lookup hit, valid with resp_valid
mem_req_valid  out  1  memory request
mem_req_write  out  1  memory request is a write
mem_addr  out  ADDRESS_WIDTH  word-aligned address (bits [1:0]=0)
mem_wdata  out  32  write data
mem_be  out  4  write byte enables
mem_ready  in  1  memory accepts request
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data

Behaviour:
- Address split: offset A[1:0], set A[SET_ADDRESS_WIDTH+1:2], tag A[ADDRESS_WIDTH-1:SET_ADDRESS_WIDTH+2].
- Line per way per set: valid bit, tag, 32-bit data. Per set: LRU age of log2(WAYS) bits per way (0 = MRU). For WAYS=1 ages are absent and the victim is always way 0.
- Reset (async, RST_N low): all valid bits 0; way i age = i; state IDLE. Outputs req_ready=0 while RST_N low, resp_valid=0, RD=0, hit_o=0, mem_req_valid=0, mem_req_write=0, mem_addr=0, mem_wdata=0, mem_be=0. A reset mid-miss abandons the request; any mem_rvalid arriving after reset is ignored.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
- IDLE: req_ready = ~flush. flush has priority and clears all valid bits at the edge; no response. On accept (req_valid & req_ready), lookup is combinational on A. Hit means valid & tag match in exactly one way.
  - Read hit: go to RESP; RD = hit data; hit_o=1; hit way becomes MRU.
  - Read miss: latch address; go to RD_REQ.
  - Write, hit or miss: latch A, WD and WE; go to WR_REQ. On a hit, the enabled bytes of the hit line are merged at the accept edge and the way becomes MRU. On a miss, no allocate and no LRU change.
- RD_REQ: mem_req_valid=1, mem_req_write=0, mem_addr = latched word address. Hold these until mem_ready, then go to RD_WAIT. mem_ready and mem_rvalid may be seen in the same cycle; go straight to the fill.
- RD_WAIT: on mem_rvalid, fill the victim with {valid=1, tag, mem_rdata}. Victim is the lowest-index invalid way, else the way with the highest age. Victim becomes MRU. Go to RESP with RD=mem_rdata and hit_o=0.
- WR_REQ: mem_req_valid=1, mem_req_write=1, mem_wdata/mem_be = latched WD/WE. On mem_ready go to RESP with hit_o = the latched hit and RD=0.
- RESP: resp_valid=1 for exactly one cycle; then IDLE. Latency: read hit gives resp_valid 1 cycle after accept. Miss and write take memory-dependent latency, minimum 2 cycles.
- LRU update: the touched way gets age 0. Ways whose age was below its old age increment. Other ways are unchanged. Ages stay a permutation of 0..WAYS-1.
- Same-set back-to-back requests: the second request sees the line state written by the first. Writes with WE=0 hit/miss normally, modify no bytes and still issue a memory write.
- flush while not IDLE is ignored.

Optional Feature:
CACHE_STATS_EN. When defined, adds outputs hit_count[31:0] and miss_count[31:0]. Each counter increments once per completed load (on resp_valid, by hit_o). Both saturate at 0xFFFFFFFF, reset to 0, and are not cleared by flush. When undefined, the ports and counters are absent and the behaviour is otherwise identical.

Test Plan:
- Reset, then load A=0x00010 (miss), memory returns 0xDEADBEEF: one RD_REQ with mem_addr=0x00010; resp_valid with RD=0xDEADBEEF, hit_o=0. Repeat the load: resp_valid 1 cycle after accept, RD=0xDEADBEEF, hit_o=1, no memory request.
- WAYS=2: load 0x00010, then 0x00030, then 0x00050 (all set 4). Touch 0x00010 again, then load 0x00050: the victim is the 0x00030 way. Reload 0x00010: hit. Reload 0x00030: miss.
- Store to cached 0x00010 with WE=0b0101, WD=0x11223344: mem write with mem_be=0101. Next load gives RD=0xDE22BE44 (0xDEADBEEF merged, bytes 0 and 2 from WD), hit_o=1.
- Store miss to 0x00070: memory write issued, hit_o=0; a following load of 0x00070 misses (no allocate).
- flush in IDLE with req_valid=1: req_ready=0 that cycle; a subsequent load of 0x00010 misses. Pull RST_N low during RD_WAIT: mem_req_valid=0 immediately and a late mem_rvalid produces no resp_valid.
- CACHE_STATS_EN: 3 hits and 2 misses give hit_count=3 and miss_count=2; a preset near-max counter saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/assoc_data_cache_if.sv
// LSU-side and memory-side bus of the associative data cache.
// The cache connects through the slave modport; the LSU/memory
// environment drives the master modport.
interface assoc_data_cache_if #(
  parameter int ADDRESS_WIDTH = 17
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [ADDRESS_WIDTH-1:0] A;
  logic [31:0]              WD;
  logic [3:0]               WE;
  logic                     flush;
  logic                     resp_valid;
  logic [31:0]              RD;
  logic                     hit_o;
  logic                     mem_req_valid;
  logic                     mem_req_write;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [31:0]              mem_wdata;
  logic [3:0]               mem_be;
  logic                     mem_ready;
  logic                     mem_rvalid;
  logic [31:0]              mem_rdata;

  modport slave (
    input  req_valid, req_write, A, WD, WE, flush, mem_ready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, RD, hit_o,
           mem_req_valid, mem_req_write, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output req_valid, req_write, A, WD, WE, flush, mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, RD, hit_o,
           mem_req_valid, mem_req_write, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/assoc_data_cache.sv
// N-way set-associative, write-through, no-write-allocate data cache.
// One word per line, LRU victim selection, byte-enabled stores, flush.
// Optional hit/miss load counters are built when CACHE_STATS_EN is defined.
//
//   state   | meaning
//   IDLE    | accepting requests / flush; lookup on the incoming address
//   RD_REQ  | read miss: memory read request held until mem_ready
//   RD_WAIT | waiting for mem_rvalid, then fill the victim way
//   WR_REQ  | write-through request held until mem_ready
//   RESP    | one-cycle resp_valid strobe
module assoc_data_cache #(
  parameter int ADDRESS_WIDTH     = 17,
  parameter int DATA_WIDTH        = 32,
  parameter int SET_ADDRESS_WIDTH = 3,
  parameter int WAYS              = 2,
  parameter int TAG_WIDTH         = ADDRESS_WIDTH - SET_ADDRESS_WIDTH - 2
) (
  input logic              CLK,
  input logic              RST_N,
  assoc_data_cache_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
`endif
);
  localparam int SETS  = 1 << SET_ADDRESS_WIDTH;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [WAYS-1:0][WAY_W-1:0] ages_t;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;

  state_t                   state_q;
  logic [WAYS-1:0]          valid_q [SETS];
  ages_t                    age_q   [SETS];
  logic [TAG_WIDTH-1:0]     tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0]    data_q  [SETS][WAYS];
  logic [ADDRESS_WIDTH-1:2] addr_q;
  logic                     whit_q;
  logic                     resp_valid_q, hit_q, mreq_valid_q, mreq_write_q;
  logic [DATA_WIDTH-1:0]    rd_q, mwdata_q;
  logic [ADDRESS_WIDTH-1:0] maddr_q;
  logic [3:0]               mbe_q;

  logic [SET_ADDRESS_WIDTH-1:0] set_in, l_set;
  logic [TAG_WIDTH-1:0]         tag_in, l_tag;
  logic [WAYS-1:0]              hit_vec;
  logic [WAY_W-1:0]             hit_way, vict;
  logic [WAY_W-1:0]             max_age;
  logic                         hit, found, req_ready, accept, fill_en, wr_hit_en;

  // Touched way becomes age 0; ways younger than it age by one.
  function automatic ages_t lru_touch(input ages_t a, input logic [WAY_W-1:0] t);
    logic [WAY_W-1:0] old;
    old = a[t];
    lru_touch = a;
    for (int w = 0; w < WAYS; w++)
      if (a[w] < old) lru_touch[w] = a[w] + 1'b1;
    lru_touch[t] = '0;
  endfunction

  assign set_in    = bus.A[SET_ADDRESS_WIDTH+1:2];
  assign tag_in    = bus.A[ADDRESS_WIDTH-1:SET_ADDRESS_WIDTH+2];
  assign l_set     = addr_q[SET_ADDRESS_WIDTH+1:2];
  assign l_tag     = addr_q[ADDRESS_WIDTH-1:SET_ADDRESS_WIDTH+2];
  assign req_ready = RST_N & (state_q == IDLE) & ~bus.flush;
  assign accept    = bus.req_valid & req_ready;
  assign fill_en   = bus.mem_rvalid & ((state_q == RD_WAIT) | ((state_q == RD_REQ) & bus.mem_ready));
  assign wr_hit_en = accept & bus.req_write & hit;

  // Tag compare on the incoming address; a hit needs exactly one matching way.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      hit_vec[w] = valid_q[set_in][w] && (tag_q[set_in][w] == tag_in);
    for (int w = WAYS - 1; w >= 0; w--)
      if (hit_vec[w]) hit_way = WAY_W'(w);
    hit = $onehot(hit_vec);
  end

  // Victim for the latched miss: lowest invalid way, otherwise the oldest way.
  always_comb begin
    vict    = '0;
    found   = 1'b0;
    max_age = age_q[l_set][0];
    for (int w = 0; w < WAYS; w++)
      if (!found && !valid_q[l_set][w]) begin
        vict  = WAY_W'(w);
        found = 1'b1;
      end
    if (!found)
      for (int w = 1; w < WAYS; w++)
        if (age_q[l_set][w] > max_age) begin
          max_age = age_q[l_set][w];
          vict    = WAY_W'(w);
        end
  end

  // Line payload storage: refill on memory data, byte merge on a store hit.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[l_set][vict]  <= l_tag;
      data_q[l_set][vict] <= bus.mem_rdata;
    end else if (wr_hit_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.WE[b]) data_q[set_in][hit_way][8*b +: 8] <= bus.WD[8*b +: 8];
    end
  end

  // Control FSM with valid bits, LRU ages and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      whit_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      rd_q         <= '0;
      hit_q        <= 1'b0;
      mreq_valid_q <= 1'b0;
      mreq_write_q <= 1'b0;
      maddr_q      <= '0;
      mwdata_q     <= '0;
      mbe_q        <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.flush) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
          end else if (bus.req_valid) begin
            addr_q  <= bus.A[ADDRESS_WIDTH-1:2];
            whit_q  <= hit;
            maddr_q <= {bus.A[ADDRESS_WIDTH-1:2], 2'b00};
            if (hit) age_q[set_in] <= lru_touch(age_q[set_in], hit_way);
            if (bus.req_write) begin
              state_q      <= WR_REQ;
              mreq_valid_q <= 1'b1;
              mreq_write_q <= 1'b1;
              mwdata_q     <= bus.WD;
              mbe_q        <= bus.WE;
            end else if (hit) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              rd_q         <= data_q[set_in][hit_way];
              hit_q        <= 1'b1;
            end else begin
              state_q      <= RD_REQ;
              mreq_valid_q <= 1'b1;
              mreq_write_q <= 1'b0;
            end
          end
        end
        RD_REQ, RD_WAIT: begin
          if (state_q == RD_REQ && bus.mem_ready) mreq_valid_q <= 1'b0;
          if (fill_en) begin
            valid_q[l_set][vict] <= 1'b1;
            age_q[l_set]         <= lru_touch(age_q[l_set], vict);
            state_q              <= RESP;
            resp_valid_q         <= 1'b1;
            rd_q                 <= bus.mem_rdata;
            hit_q                <= 1'b0;
          end else if (state_q == RD_REQ && bus.mem_ready) begin
            state_q <= RD_WAIT;
          end
        end
        WR_REQ: begin
          if (bus.mem_ready) begin
            mreq_valid_q <= 1'b0;
            mreq_write_q <= 1'b0;
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            rd_q         <= '0;
            hit_q        <= whit_q;
          end
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.RD            = rd_q;
  assign bus.hit_o         = hit_q;
  assign bus.mem_req_valid = mreq_valid_q;
  assign bus.mem_req_write = mreq_write_q;
  assign bus.mem_addr      = maddr_q;
  assign bus.mem_wdata     = mwdata_q;
  assign bus.mem_be        = mbe_q;

`ifdef CACHE_STATS_EN
  logic        ld_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating load hit/miss counters, bumped on each load's response strobe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ld_q       <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (accept) ld_q <= ~bus.req_write;
      if (resp_valid_q && ld_q) begin
        if (hit_q && hit_cnt_q != 32'hFFFF_FFFF)        hit_cnt_q  <= hit_cnt_q + 32'd1;
        else if (!hit_q && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_assoc_data_cache.sv
// Self-checking bench for assoc_data_cache (WAYS=2, 8 sets).
// Reference: per-set recency lists of tags plus a word-addressed memory image.
module tb_assoc_data_cache;
  localparam int AW   = 17;
  localparam int SW   = 3;
  localparam int WAYS = 2;
  localparam int SETS = 1 << SW;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  assoc_data_cache_if #(.ADDRESS_WIDTH(AW)) bus ();
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  assoc_data_cache #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(32), .SET_ADDRESS_WIDTH(SW), .WAYS(WAYS)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          lru_m [SETS][$];
  logic [31:0] mem_m [int];
  int          exp_hits = 0;
  int          exp_miss = 0;
  logic        last_hit;
  logic [31:0] rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input int w);
    if (mem_m.exists(w)) return mem_m[w];
    return (32'(w) * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic int find_tag(input int s, input int t);
    for (int i = 0; i < lru_m[s].size(); i++)
      if (lru_m[s][i] == t) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) lru_m[s].delete();
  endtask

  // One LSU transaction with a memory responder; starts and ends on a negedge.
  task automatic do_op(input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                       input logic [3:0] we, input int rdy_lat, input int rv_lat,
                       output logic [31:0] rd_obs);
    int s, t, widx, pos, cyc, nreq, wait_r, rv_cnt;
    bit exp_hit, active, in_rw, got;
    logic [31:0] exp_rd;
    widx = int'(a[AW-1:2]);
    s    = int'(a[SW+1:2]);
    t    = int'(a[AW-1:SW+2]);
    pos  = find_tag(s, t);
    exp_hit = (pos >= 0);
    if (exp_hit) begin
      lru_m[s].delete(pos);
      lru_m[s].push_front(t);
    end
    if (wr) begin
      mem_m[widx] = merge(mem_rd(widx), wd, we);
      exp_rd = 32'h0;
    end else begin
      exp_rd = mem_rd(widx);
      if (exp_hit) exp_hits++;
      else begin
        exp_miss++;
        if (lru_m[s].size() == WAYS) void'(lru_m[s].pop_back());
        lru_m[s].push_front(t);
      end
    end

    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.A         = a;
    bus.WD        = wd;
    bus.WE        = we;
    #1;
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);

    cyc = 0; got = 0; nreq = 0; active = 0; in_rw = 0; wait_r = 0; rv_cnt = 0;
    rd_obs = 32'h0;
    while (!got && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      bus.req_valid  = 1'b0;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h0;
      if (bus.resp_valid) begin
        got      = 1;
        rd_obs   = bus.RD;
        last_hit = bus.hit_o;
      end else begin
        if (bus.mem_req_valid && !active) begin
          active = 1;
          nreq++;
          wait_r = rdy_lat;
          check("mem_req_write", 32'(bus.mem_req_write), 32'(wr));
          check("mem_addr", 32'(bus.mem_addr), 32'({a[AW-1:2], 2'b00}));
          if (wr) begin
            check("mem_wdata", bus.mem_wdata, wd);
            check("mem_be", 32'(bus.mem_be), 32'(we));
          end
        end
        if (active) begin
          if (wait_r == 0) begin
            bus.mem_ready = 1'b1;
            active = 0;
            if (!wr) begin
              if (rv_lat == 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = exp_rd;
              end else begin
                in_rw  = 1;
                rv_cnt = rv_lat;
              end
            end
          end else wait_r--;
        end else if (in_rw) begin
          rv_cnt--;
          if (rv_cnt == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = exp_rd;
            in_rw = 0;
          end
        end
      end
    end
    check("resp_arrived", 32'(got), 32'd1);
    if (got) begin
      check("resp_rd", rd_obs, exp_rd);
      check("resp_hit", 32'(last_hit), 32'(exp_hit));
      check("mem_req_count", 32'(nreq), (wr || !exp_hit) ? 32'd1 : 32'd0);
      if (!wr && exp_hit) check("hit_latency", 32'(cyc), 32'd1);
    end
    @(negedge CLK);
    check("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
    check("mem_idle_after", 32'(bus.mem_req_valid), 32'd0);
  endtask

  task automatic do_flush();
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.A         = 17'h00010;
    #1;
    check("flush_ready_low", 32'(bus.req_ready), 32'd0);
    @(negedge CLK);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    check("flush_no_resp", 32'(bus.resp_valid), 32'd0);
    check("flush_no_mem", 32'(bus.mem_req_valid), 32'd0);
    model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.A          = '0;
    bus.WD         = '0;
    bus.WE         = '0;
    bus.flush      = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    model_clear();

    repeat (2) @(negedge CLK);
    bus.req_valid = 1'b1;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_rd", bus.RD, 32'd0);
    check("rst_hit", 32'(bus.hit_o), 32'd0);
    check("rst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst_mem_write", 32'(bus.mem_req_write), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_be", 32'(bus.mem_be), 32'd0);
    bus.req_valid = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    mem_m[32'h10 >> 2] = 32'hDEAD_BEEF;

    do_op(0, 17'h00010, 0, 0, 0, 1, rd);
    check("tp_miss_data", rd, 32'hDEAD_BEEF);
    check("tp_miss_hit", 32'(last_hit), 32'd0);
    do_op(0, 17'h00010, 0, 0, 1, 0, rd);
    check("tp_hit_data", rd, 32'hDEAD_BEEF);
    check("tp_hit_hit", 32'(last_hit), 32'd1);

    do_op(0, 17'h00030, 0, 0, 0, 0, rd);
    do_op(0, 17'h00050, 0, 0, 2, 2, rd);
    do_op(0, 17'h00010, 0, 0, 0, 1, rd);
    check("lru_touch_miss", 32'(last_hit), 32'd0);
    do_op(0, 17'h00050, 0, 0, 0, 0, rd);
    check("lru_keep_mru", 32'(last_hit), 32'd1);
    do_op(0, 17'h00010, 0, 0, 0, 0, rd);
    check("lru_reload_hit", 32'(last_hit), 32'd1);
    do_op(0, 17'h00030, 0, 0, 1, 1, rd);
    check("lru_victim_miss", 32'(last_hit), 32'd0);

    do_op(1, 17'h00010, 32'h1122_3344, 4'b0101, 0, 0, rd);
    check("st_hit_flag", 32'(last_hit), 32'd1);
    do_op(0, 17'h00010, 0, 0, 0, 0, rd);
    check("st_merge_data", rd, 32'hDE22_BE44);
    check("st_merge_hit", 32'(last_hit), 32'd1);

    do_op(1, 17'h00070, 32'hA5A5_5A5A, 4'b1111, 1, 0, rd);
    check("st_miss_flag", 32'(last_hit), 32'd0);
    do_op(0, 17'h00070, 0, 0, 0, 0, rd);
    check("no_allocate", 32'(last_hit), 32'd0);
    do_op(1, 17'h00070, 32'hFFFF_FFFF, 4'b0000, 0, 0, rd);
    check("we0_hit", 32'(last_hit), 32'd1);

    do_flush();
    do_op(0, 17'h00010, 0, 0, 0, 0, rd);
    check("flush_then_miss", 32'(last_hit), 32'd0);

    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.A         = 17'h00090;
    @(negedge CLK);
    bus.req_valid = 1'b0;
    check("rr_mem_req", 32'(bus.mem_req_valid), 32'd1);
    bus.mem_ready = 1'b1;
    @(negedge CLK);
    bus.mem_ready = 1'b0;
    RST_N = 1'b0;
    #1;
    check("rr_mem_valid_low", 32'(bus.mem_req_valid), 32'd0);
    check("rr_ready_low", 32'(bus.req_ready), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      bus.mem_rvalid = 1'b0;
      check("rr_no_resp", 32'(bus.resp_valid), 32'd0);
      check("rr_no_mem", 32'(bus.mem_req_valid), 32'd0);
    end
    bus.mem_rdata = 32'h0;
    model_clear();
    exp_hits = 0;
    exp_miss = 0;
    do_op(0, 17'h00010, 0, 0, 0, 0, rd);
    check("rst_clears_cache", 32'(last_hit), 32'd0);
    do_op(0, 17'h00010, 0, 0, 0, 0, rd);
    do_op(0, 17'h00010, 0, 0, 0, 0, rd);

    for (int i = 0; i < 200; i++) begin
      logic [AW-1:0] ra;
      ra = AW'(($urandom_range(0, 4) << (SW + 2)) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) do_flush();
      else if ($urandom_range(0, 9) < 3)
        do_op(1, ra, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), 0, rd);
      else
        do_op(0, ra, 0, 0, $urandom_range(0, 2), $urandom_range(0, 2), rd);
    end

`ifdef CACHE_STATS_EN
    check("stat_hits", hit_count, 32'(exp_hits));
    check("stat_misses", miss_count, 32'(exp_miss));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
